// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: per-stage payload structs for the pipeline registers and an occupancy helper.
package pipe_stage_reg_pkg;

    localparam int OCC_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1_data;
        logic [31:0] reg2_data;
        logic [4:0]  waddr;
        logic        wreg;
    } id_ex_t;

    typedef struct packed {
        logic [4:0]  waddr;
        logic        wreg;
        logic [31:0] wdata;
    } ex_mem_t;

    typedef struct packed {
        logic [4:0]  waddr;
        logic        wreg;
        logic [31:0] wdata;
    } mem_wb_t;

    function automatic logic [OCC_W-1:0] beat_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one valid+data holding register; clear beats load on valid, data only follows loads.
module pipe_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        vld_d  = clr_i ? 1'b0 : ld_i ? 1'b1 : vld_q;
        data_d = ld_i ? d_i : data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with flush and optional 2-entry skid buffer.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_rdy,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_rdy,
    output logic [OCC_W-1:0]  occ
);

    logic              m_vld, s_vld;
    logic [DATA_W-1:0] m_data, s_data, m_d;
    logic              m_free, in_fire, m_ld, m_clr, s_ld, s_clr;

    // S only fills while M is held, so M always holds the oldest beat.
    always_comb begin
        m_free  = !m_vld | out_rdy;
        in_rdy  = (SKID != 0) ? !s_vld : m_free;
        in_fire = in_vld & in_rdy;
        m_ld    = m_free & (s_vld | in_fire);
        m_d     = s_vld ? s_data : in_data;
        m_clr   = flush | (m_free & !s_vld & !in_fire);
        s_ld    = !m_free & in_fire;
        s_clr   = flush | (m_free & s_vld);
    end

    pipe_slot #(.W(DATA_W)) u_m (
        .clk    (clk),
        .rst    (rst),
        .ld_i   (m_ld),
        .clr_i  (m_clr),
        .d_i    (m_d),
        .vld_o  (m_vld),
        .data_o (m_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.W(DATA_W)) u_s (
                .clk    (clk),
                .rst    (rst),
                .ld_i   (s_ld),
                .clr_i  (s_clr),
                .d_i    (in_data),
                .vld_o  (s_vld),
                .data_o (s_data)
            );
        end else begin : g_noskid
            assign s_vld  = 1'b0;
            assign s_data = '0;
        end
    endgenerate

    assign out_vld  = m_vld;
    assign out_data = m_data;
    assign occ      = beat_count(m_vld, s_vld);

endmodule
